// File: rtl/uart_poll_port.sv
// Polled 8N1 UART with optional RX interrupt for the z80mini CPLD.
// One TX holding register, one RX buffer, 16x oversampling from CLK50MHz.
module uart_poll_port #(
    parameter int unsigned OVS_DIV = 27
) (
    input  logic       CLK50MHz,
    input  logic       nRESET,
    input  logic       cpu_clk0,
    input  logic       cs,
    input  logic       nIORQ,
    input  logic       nRD,
    input  logic       nWR,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);

    localparam int unsigned     DIV_W    = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OVS_DIV - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic       rd_act, wr_act, rd_q, wr_q, rd_a0_q;
    logic       wr_acc, rd_end, data_wr, ctrl_wr, data_rd_end, stat_rd_end;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    logic [7:0] hold, rx_data;
    logic       hold_full, rx_ready, ovr, ferr, rxie;

    tx_state_t  tx_state, tx_state_n;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bcnt;
    logic [7:0] tx_shift;
    logic       tx_load;

    rx_state_t  rx_state, rx_state_n;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bcnt;
    logic [7:0] rx_shift;
    logic       rx_s1, rx_s2, rx_done, rx_store, rx_ovr_set;

    // Bus edges are detected only on CPU clock phases, so one access gives one event.
    assign rd_act      = cs & ~nIORQ & ~nRD;
    assign wr_act      = cs & ~nIORQ & ~nWR;
    assign wr_acc      = cpu_clk0 & wr_act & ~wr_q;
    assign rd_end      = cpu_clk0 & ~rd_act & rd_q;
    assign data_wr     = wr_acc & ~a0;
    assign ctrl_wr     = wr_acc & a0;
    assign data_rd_end = rd_end & ~rd_a0_q;
    assign stat_rd_end = rd_end & rd_a0_q;

    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_a0_q <= 1'b0;
        end else if (cpu_clk0) begin
            rd_q <= rd_act;
            wr_q <= wr_act;
            if (rd_act) rd_a0_q <= a0;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge CLK50MHz) begin
        if (!nRESET)   div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    // TX: state register
    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_n;
            if (tx_load) begin
                tx_shift <= hold;
                tx_tcnt  <= '0;
                tx_bcnt  <= '0;
            end else if (tick && tx_state != TX_IDLE) begin
                tx_tcnt <= tx_tcnt + 4'd1;
                if (tx_state == TX_DATA && tx_tcnt == 4'd15) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bcnt  <= tx_bcnt + 3'd1;
                end
            end
        end
    end

    // TX: next state; a full holding register at the end of STOP chains straight into START
    always_comb begin
        tx_state_n = tx_state;
        tx_load    = 1'b0;
        case (tx_state)
            TX_IDLE:  if (hold_full) begin
                          tx_state_n = TX_START;
                          tx_load    = 1'b1;
                      end
            TX_START: if (tick && tx_tcnt == 4'd15) tx_state_n = TX_DATA;
            TX_DATA:  if (tick && tx_tcnt == 4'd15 && tx_bcnt == 3'd7) tx_state_n = TX_STOP;
            TX_STOP:  if (tick && tx_tcnt == 4'd15) begin
                          if (hold_full) begin
                              tx_state_n = TX_START;
                              tx_load    = 1'b1;
                          end else begin
                              tx_state_n = TX_IDLE;
                          end
                      end
            default:  tx_state_n = TX_IDLE;
        endcase
    end

    // TX: outputs
    always_comb begin
        txd = 1'b1;
        case (tx_state)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_shift[0];
            default:  txd = 1'b1;
        endcase
    end

    // RX: state register and 2-FF synchronizer
    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_state <= rx_state_n;
            if (rx_state == RX_IDLE) begin
                rx_tcnt <= '0;
                rx_bcnt <= '0;
            end else if (tick) begin
                rx_tcnt <= (rx_state == RX_START && rx_tcnt == 4'd7) ? 4'd0 : rx_tcnt + 4'd1;
                if (rx_state == RX_DATA && rx_tcnt == 4'd15) begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bcnt  <= rx_bcnt + 3'd1;
                end
            end
        end
    end

    // RX: next state; START re-checks the line half a bit in to reject glitches
    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            RX_IDLE:  if (tick && !rx_s2) rx_state_n = RX_START;
            RX_START: if (tick && rx_tcnt == 4'd7) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && rx_tcnt == 4'd15 && rx_bcnt == 3'd7) rx_state_n = RX_STOP;
            RX_STOP:  if (tick && rx_tcnt == 4'd15) rx_state_n = RX_IDLE;
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    // RX: outputs; a completing byte beats a simultaneous data-read end
    always_comb begin
        rx_done    = (rx_state == RX_STOP) && tick && (rx_tcnt == 4'd15);
        rx_store   = rx_done & (~rx_ready | data_rd_end);
        rx_ovr_set = rx_done & rx_ready & ~data_rd_end;
    end

    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            hold      <= '0;
            hold_full <= 1'b0;
            rx_data   <= '0;
            rx_ready  <= 1'b0;
            ovr       <= 1'b0;
            ferr      <= 1'b0;
            rxie      <= 1'b0;
        end else begin
            if (ctrl_wr) rxie <= din[7];

            if (tx_load) begin
                hold_full <= 1'b0;
            end else if (data_wr && !hold_full) begin
                hold      <= din;
                hold_full <= 1'b1;
            end

            if (rx_store) begin
                rx_data  <= rx_shift;
                rx_ready <= 1'b1;
            end else if (data_rd_end) begin
                rx_ready <= 1'b0;
            end

            if (rx_store)         ferr <= ~rx_s2;
            else if (stat_rd_end) ferr <= 1'b0;

            if (rx_ovr_set)       ovr <= 1'b1;
            else if (stat_rd_end) ovr <= 1'b0;
        end
    end

    assign dout = a0 ? {rxie, 3'b000, ferr, ovr, ~hold_full, rx_ready} : rx_data;
    assign irq  = rx_ready & rxie;

endmodule

// File: tb/tb_uart_poll_port.sv
// Randomized self-checking bench for uart_poll_port against a transaction-level
// model of the register flags and a TX line monitor.
module tb_uart_poll_port;

    localparam int unsigned BIT_TX = 432;   // 16 ticks * 27 cycles
    localparam int unsigned BIT_RX = 434;   // 115200 baud at 50 MHz

    logic       CLK50MHz = 1'b0;
    logic       nRESET   = 1'b0;
    logic       cpu_clk0 = 1'b0;
    logic       cs       = 1'b0;
    logic       nIORQ    = 1'b1;
    logic       nRD      = 1'b1;
    logic       nWR      = 1'b1;
    logic       a0       = 1'b0;
    logic [7:0] din      = 8'h00;
    logic [7:0] dout;
    logic       rxd      = 1'b1;
    logic       txd;
    logic       irq;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;

    // reference model state
    logic       m_ready = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_rxie = 1'b0;
    logic       m_hold_full = 1'b0, m_tx_busy = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] exp_tx[$];
    logic [9:0] txq[$];
    int unsigned txt[$];

    uart_poll_port #(.OVS_DIV(27)) dut (
        .CLK50MHz (CLK50MHz),
        .nRESET   (nRESET),
        .cpu_clk0 (cpu_clk0),
        .cs       (cs),
        .nIORQ    (nIORQ),
        .nRD      (nRD),
        .nWR      (nWR),
        .a0       (a0),
        .din      (din),
        .dout     (dout),
        .rxd      (rxd),
        .txd      (txd),
        .irq      (irq)
    );

    always #10 CLK50MHz = ~CLK50MHz;
    always @(posedge CLK50MHz) cyc <= cyc + 1;

    initial begin : cpu_phase
        forever begin
            @(negedge CLK50MHz);
            cpu_clk0 = (cyc % 4 == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {m_rxie, 3'b000, m_ferr, m_ovr, ~m_hold_full, m_ready};
    endfunction

    // Samples every frame on txd at mid-bit: {stop, data[7:0], start}
    initial begin : tx_mon
        logic [9:0]  w;
        int unsigned t0;
        forever begin
            @(negedge CLK50MHz);
            if (txd === 1'b0 && nRESET === 1'b1) begin
                t0 = cyc;
                repeat (215) @(negedge CLK50MHz);
                w[0] = txd;
                for (int i = 1; i < 10; i++) begin
                    repeat (BIT_TX) @(negedge CLK50MHz);
                    w[i] = txd;
                end
                txq.push_back(w);
                txt.push_back(t0);
            end
        end
    end

    task automatic io_write(input logic a, input logic [7:0] d);
        @(negedge CLK50MHz);
        cs = 1'b1; a0 = a; din = d; nIORQ = 1'b0; nWR = 1'b0;
        repeat (12) @(negedge CLK50MHz);
        cs = 1'b0; nIORQ = 1'b1; nWR = 1'b1;
        repeat (8) @(negedge CLK50MHz);
    endtask

    task automatic io_read(input logic a, output logic [7:0] d);
        @(negedge CLK50MHz);
        cs = 1'b1; a0 = a; nIORQ = 1'b0; nRD = 1'b0;
        repeat (8) @(negedge CLK50MHz);
        d = dout;
        cs = 1'b0; nIORQ = 1'b1; nRD = 1'b1;
        repeat (8) @(negedge CLK50MHz);
    endtask

    task automatic rd_status(input string tag);
        logic [7:0] v;
        io_read(1'b1, v);
        check(tag, v, exp_status());
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic rd_data(input string tag);
        logic [7:0] v;
        io_read(1'b0, v);
        check(tag, v, m_data);
        m_ready = 1'b0;
    endtask

    task automatic wr_ctrl(input logic ie);
        io_write(1'b1, {ie, 7'h00});
        m_rxie = ie;
    endtask

    // A byte is accepted only when the holding register is empty; it goes
    // straight to the shifter if nothing is being sent.
    task automatic wr_data(input logic [7:0] d);
        io_write(1'b0, d);
        if (!m_hold_full) begin
            exp_tx.push_back(d);
            if (m_tx_busy) m_hold_full = 1'b1;
            else           m_tx_busy   = 1'b1;
        end
    endtask

    task automatic wait_tx_done();
        int unsigned budget;
        logic [7:0]  e;
        budget = 5000 * exp_tx.size() + 1000;
        for (int k = 0; k < budget && txq.size() < exp_tx.size(); k++)
            @(negedge CLK50MHz);
        if (txq.size() < exp_tx.size())
            check("tx_timeout", txq.size(), exp_tx.size());
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            if (txq.size() > 0) check("tx_frame", txq.pop_front(), {1'b1, e, 1'b0});
        end
        repeat (500) @(negedge CLK50MHz);
        m_tx_busy   = 1'b0;
        m_hold_full = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(negedge CLK50MHz);
        for (int i = 0; i < 9; i++) begin
            rxd = f[i];
            repeat (BIT_RX) @(negedge CLK50MHz);
        end
        rxd = stop;
        repeat (stop ? BIT_RX : 260) @(negedge CLK50MHz);
        rxd = 1'b1;
        repeat (BIT_RX) @(negedge CLK50MHz);
        if (!m_ready) begin
            m_data  = b;
            m_ready = 1'b1;
            m_ferr  = ~stop;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic idle_txd(input string tag);
        int unsigned lows;
        lows = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge CLK50MHz);
            if (txd !== 1'b1) lows++;
        end
        check(tag, lows, 0);
    endtask

    initial begin : stim
        int unsigned gap;
        logic [7:0]  tb_byte, rb_byte;
        logic        stop, rie;

        // reset state
        repeat (5) @(negedge CLK50MHz);
        nRESET = 1'b1;
        repeat (4) @(negedge CLK50MHz);
        rd_status("rst_status");
        check("rst_irq", irq, 1'b0);
        idle_txd("rst_txd_idle");

        // single frame
        wr_data(8'h55);
        rd_status("tx1_status");
        wait_tx_done();

        // back-to-back frames; third write hits a full holding register
        txt.delete();
        wr_data(8'hA5);
        wr_data(8'h3C);
        wr_data(8'hFF);
        rd_status("tx_full_status");
        wait_tx_done();
        gap = (txt.size() >= 2) ? txt[1] - txt[0] : 0;
        check("b2b_gap", (gap >= 9 * BIT_TX + 400) && (gap <= 10 * BIT_TX + 2), 1'b1);
        idle_txd("no_third_frame");

        // receive with interrupt enabled
        wr_ctrl(1'b1);
        send_rx(8'hC3, 1'b1);
        check("irq_set", irq, m_ready & m_rxie);
        rd_status("rx_status");
        check("irq_hold", irq, m_ready & m_rxie);
        rd_data("rx_data");
        check("irq_clr", irq, m_ready & m_rxie);
        rd_status("rx_status_empty");
        wr_ctrl(1'b0);

        // overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd_data("ovr_data");
        rd_status("ovr_status");
        rd_status("ovr_cleared");

        // framing error, then a glitch that must not start a byte
        send_rx(8'h5A, 1'b0);
        rd_status("ferr_status");
        rd_data("ferr_data");
        rd_status("ferr_cleared");
        @(negedge CLK50MHz);
        rxd = 1'b0;
        repeat (100) @(negedge CLK50MHz);
        rxd = 1'b1;
        repeat (1000) @(negedge CLK50MHz);
        rd_status("glitch_status");

        // randomized traffic, TX and RX overlapping
        for (int it = 0; it < 4; it++) begin
            tb_byte = 8'($urandom);
            rb_byte = 8'($urandom);
            stop    = ($urandom_range(0, 3) != 0);
            rie     = 1'($urandom_range(0, 1));
            wr_ctrl(rie);
            wr_data(tb_byte);
            send_rx(rb_byte, stop);
            check("rnd_irq", irq, m_ready & m_rxie);
            case ($urandom_range(0, 2))
                1: rd_status("rnd_status");
                2: begin
                       rd_data("rnd_data");
                       rd_status("rnd_status2");
                   end
                default: ;
            endcase
            wait_tx_done();
        end
        rd_status("rnd_final_status");

        // reset in the middle of a frame
        wr_data(8'h00);
        repeat (1000) @(negedge CLK50MHz);
        check("pre_reset_txd", txd, 1'b0);
        nRESET = 1'b0;
        @(posedge CLK50MHz);
        #1;
        check("reset_txd", txd, 1'b1);
        repeat (3) @(negedge CLK50MHz);
        nRESET = 1'b1;
        m_ready = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_rxie = 1'b0;
        m_hold_full = 1'b0; m_tx_busy = 1'b0;
        exp_tx.delete();
        check("reset_irq", irq, 1'b0);
        rd_status("post_reset_status");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
